// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
// Holds the FSM state encoding, the wait-state limit and the byte-to-word offset.
package dmem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WORD_OFFSET     = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM with a registered, enable-gated read port.
// The read register holds its value between reads and can be cleared on a read.
module dmem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: word-addressed data memory with a fixed number of
// wait states, stalling the pipeline until the access completes.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memReadIn,
    input  logic                  memWriteIn,
    input  logic [31:0]           addrIn,
    input  logic [DATA_WIDTH-1:0] writeDataIn,
    output logic [DATA_WIDTH-1:0] readDataOut,
    output logic                  stallOut,
    output logic                  respValidOut,
    output logic                  misalignedOut
);

    localparam int         WS_CLAMP = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [3:0] WS       = 4'(WS_CLAMP);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [3:0]            count;
    logic                  op_write;
    logic                  mis_lat;
    logic [ADDR_WIDTH-1:0] idx_lat;
    logic [DATA_WIDTH-1:0] wdata_lat;

    logic                  req;
    logic                  in_mis;
    logic [ADDR_WIDTH-1:0] in_idx;
    logic                  unused_addr_bits;

    logic                  access;
    logic                  acc_write;
    logic                  acc_mis;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  arr_we;
    logic                  arr_re;

    assign req              = memReadIn | memWriteIn;
    assign in_idx           = addrIn[WORD_OFFSET +: ADDR_WIDTH];
    assign in_mis           = |addrIn[WORD_OFFSET-1:0];
    assign unused_addr_bits = ^addrIn[31:ADDR_WIDTH+WORD_OFFSET];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (WS == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access edge is also the accept edge, so the live
    // inputs are used there; otherwise the values latched at accept are used.
    assign access    = (state_next == DONE) && (state != DONE);
    assign acc_write = (state == IDLE) ? memWriteIn  : op_write;
    assign acc_mis   = (state == IDLE) ? in_mis      : mis_lat;
    assign acc_idx   = (state == IDLE) ? in_idx      : idx_lat;
    assign acc_wdata = (state == IDLE) ? writeDataIn : wdata_lat;

    assign arr_we = access & acc_write & ~acc_mis & ~reset;
    assign arr_re = access & (~acc_write | acc_mis) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            op_write <= 1'b0;
            mis_lat  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        count    <= WS;
                        op_write <= memWriteIn;
                        mis_lat  <= in_mis;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idx_lat   <= in_idx;
            wdata_lat <= writeDataIn;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .clr   (acc_mis),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (readDataOut)
    );

    // A sampled reset releases the pipeline immediately, even mid-access.
    assign stallOut      = ~reset & (((state == IDLE) & req) | (state == WAIT));
    assign respValidOut  = (state == DONE);
    assign misalignedOut = (state == DONE) & mis_lat;

endmodule
